// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states, width.
package muldiv_pkg;

    localparam int unsigned MD_WIDTH = 32;

    typedef enum logic [2:0] {
        MD_OP_MULT  = 3'b000,
        MD_OP_MULTU = 3'b001,
        MD_OP_DIV   = 3'b010,
        MD_OP_DIVU  = 3'b011
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } md_state_e;

    // Ops with bit 2 set are reserved.
    function automatic logic md_op_valid(input logic [2:0] op);
        return ~op[2];
    endfunction

    // MULT and DIV are signed; MULTU and DIVU have op[0] set.
    function automatic logic md_op_signed(input logic [2:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_addsub.sv
// Combinational add/subtract with carry-out, shared by multiply and divide steps.
module muldiv_addsub
    import muldiv_pkg::*;
#(
    parameter int unsigned W = MD_WIDTH
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         sub,
    output logic [W-1:0] sum_c,
    output logic         cout_c
);

    logic [W-1:0] y_eff;

    // Subtraction is x + ~y + 1; carry-out high means no borrow.
    always_comb begin
        y_eff           = sub ? ~y : y;
        {cout_c, sum_c} = {1'b0, x} + {1'b0, y_eff} + (W+1)'(sub);
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one add/subtract per RUN cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH,
    parameter int unsigned ITER  = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(ITER);
    localparam int unsigned PW    = 2 * WIDTH;

    md_state_e        state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] bit_idx;
    logic             is_div;
    logic             sign_a;
    logic             sign_b;
    logic             div0;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [PW-1:0]    work;
    logic [PW-1:0]    work_next;

    logic [WIDTH-1:0] as_x;
    logic [WIDTH-1:0] as_y;
    logic [WIDTH-1:0] as_sum;
    logic             as_sub;
    logic             as_cout;
    logic             keep;

    logic             launch_signed;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [PW-1:0]    prod_fix;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;

    muldiv_addsub #(.W(WIDTH)) u_addsub (
        .x      (as_x),
        .y      (as_y),
        .sub    (as_sub),
        .sum_c  (as_sum),
        .cout_c (as_cout)
    );

    // Operand magnitudes at launch; unsigned ops take the raw operands.
    always_comb begin
        launch_signed = md_op_signed(op);
        a_abs = (launch_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        b_abs = (launch_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    end

    // One iteration: LSB-first shift-add, or restoring trial subtraction MSB-first.
    always_comb begin
        bit_idx   = CNT_W'(WIDTH - 1) - count;
        as_x      = work[PW-1:WIDTH];
        as_y      = mag_a;
        as_sub    = 1'b0;
        keep      = 1'b0;
        work_next = {1'b0, work[PW-1:1]};
        if (is_div) begin
            as_x      = {work[PW-2:WIDTH], mag_a[bit_idx]};
            as_y      = mag_b;
            as_sub    = 1'b1;
            keep      = work[PW-1] | as_cout;
            work_next = {(keep ? as_sum : as_x), work[WIDTH-2:0], keep};
        end else if (mag_b[count]) begin
            work_next = {as_cout, as_sum, work[WIDTH-1:1]};
        end
    end

    // Sign correction; divide-by-zero bypasses the datapath result.
    always_comb begin
        prod_fix = (sign_a ^ sign_b) ? (~work + PW'(1)) : work;
        fix_hi   = prod_fix[PW-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (div0) begin
                fix_hi = a_raw;
                fix_lo = '1;
            end else begin
                fix_lo = (sign_a ^ sign_b) ? (~work[WIDTH-1:0] + WIDTH'(1)) : work[WIDTH-1:0];
                fix_hi = sign_a ? (~work[PW-1:WIDTH] + WIDTH'(1)) : work[PW-1:WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            count       <= '0;
            is_div      <= 1'b0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            div0        <= 1'b0;
            a_raw       <= '0;
            mag_a       <= '0;
            mag_b       <= '0;
            work        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (md_op_valid(op)) begin
                            is_div <= op[1];
                            sign_a <= launch_signed & a[WIDTH-1];
                            sign_b <= launch_signed & b[WIDTH-1];
                            div0   <= (b == '0);
                            a_raw  <= a;
                            mag_a  <= a_abs;
                            mag_b  <= b_abs;
                            work   <= '0;
                            count  <= '0;
                            busy   <= 1'b1;
                            state  <= ST_RUN;
                        end
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                ST_RUN: begin
                    work  <= work_next;
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(ITER - 1)) state <= ST_FIX;
                end
                ST_FIX: begin
                    hi          <= fix_hi;
                    lo          <= fix_lo;
                    div_by_zero <= is_div & div0;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
